mem_wb_stage: RTL and testbench
===============================

# mem_wb_stage

MEM/WB pipeline stage of the 5-stage RISC-V core: captures the instruction leaving MEM, performs load byte/halfword extraction and sign/zero extension, selects the write-back value, and registers it. Its registered outputs drive the register-file write port and are the MEM_WB_* operands consumed by the EX-stage forwarding logic. It also maintains a retired-instruction counter.

## Interface
- XLEN, 32, datapath width
- CNT_W, 32, retired-instruction counter width
- clk  in  1  clock, all state on rising edge
- rst_n  in  1  asynchronous, active-low reset
- stall  in  1  hold all MEM/WB registers and the counter
- flush  in  1  load a bubble into MEM/WB
- EX_MEM_valid  in  1  instruction in MEM is real (not a bubble)
- EX_MEM_rd_addr  in  5  destination register
- EX_MEM_RegWrite  in  1  instruction writes rd
- EX_MEM_MemtoReg  in  2  write-back select: 00 ALU, 01 load, 10 PC+4, 11 reserved
- EX_MEM_funct3  in  3  load type (000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU)
- EX_MEM_alu_result  in  XLEN  ALU result / load address
- EX_MEM_pc_plus4  in  XLEN  link value for JAL/JALR
- mem_rdata  in  XLEN  aligned data-memory read word, valid combinationally in the MEM cycle
- MEM_WB_valid  out  1  registered valid
- MEM_WB_rd_addr  out  5  registered destination
- MEM_WB_RegWrite  out  1  registered write enable, = valid & RegWrite
- MEM_WB_wdata  out  XLEN  registered write-back data
- retired_count  out  CNT_W  retired-instruction count

## Operation
- Load extraction (combinational, MEM cycle), offset = EX_MEM_alu_result[1:0]:
  - LB/LBU: byte at mem_rdata[8*offset+7 : 8*offset], sign-/zero-extended to XLEN.
  - LH/LHU: half selected by offset[1] only (offset[0] ignored), sign-/zero-extended.
  - LW and undefined funct3 (011, 110, 111): full word, offset ignored.
- Write-back mux: 00 ALU result, 01 extracted load, 10 pc_plus4, 11 all-zero data.
- Register update priority: reset > flush > stall > capture.
  - flush: MEM_WB_valid=0, MEM_WB_RegWrite=0, rd_addr=0, wdata=0 (flush wins over stall).
  - stall (no flush): all registers hold.
  - capture: valid<=EX_MEM_valid; RegWrite<=EX_MEM_valid & EX_MEM_RegWrite; rd_addr, wdata from MEM stage.
- rd_addr=0 is passed through unchanged; suppression of x0 writes is the consumer's job.
- Counter: increments by 1 on every edge where a capture occurs with EX_MEM_valid=1; bubbles, stalls and flushes do not count; wraps from 2^CNT_W-1 to 0.

## Timing
- Latency 1 cycle: MEM-stage inputs at edge N appear on MEM_WB_* after edge N.
- retired_count reflects the capture at the same edge as MEM_WB_valid.
- Reset (asynchronous assert, synchronous-to-clk deassert by the system): all outputs 0, including retired_count; reset mid-stall/mid-flush drops all state immediately.
- No combinational path from any input to any output.

## Configuration
- RETIRE_CNT_EN: defined -> counter implemented as above; undefined -> no counter flops, retired_count tied to 0. Pipeline behaviour identical either way.

## Test plan
- Reset: hold rst_n=0 with active inputs -> all outputs 0; release, capture ALU op rd=5, alu_result=0x1234 -> next cycle valid=1, RegWrite=1, rd_addr=5, wdata=0x00001234, retired_count=1.
- Loads: mem_rdata=0x80F1_7F82; LB off=0 -> 0xFFFFFF82; LBU off=3 -> 0x00000080; LH off=2 -> 0xFFFF80F1; LHU off=1 -> 0x00007F82; LW off=2 -> 0x80F17F82.
- JAL: MemtoReg=10, pc_plus4=0x104, rd=1 -> wdata=0x104; MemtoReg=11 -> wdata=0.
- Stall/flush: capture rd=7, then stall 3 cycles with changing inputs -> outputs and counter frozen; stall+flush together -> valid=0, RegWrite=0, rd=0, wdata=0, counter unchanged.
- Bubble/wrap: EX_MEM_valid=0 with RegWrite=1 -> MEM_WB_RegWrite=0, no count; CNT_W=4, 16 valid captures -> retired_count returns to 0; with RETIRE_CNT_EN undefined retired_count stays 0.

Source files
------------

// File: rtl/mem_wb_stage.sv
// mem_wb_stage: MEM/WB pipeline register with load extraction, write-back select and optional retired-instruction counter (RETIRE_CNT_EN)
module mem_wb_stage #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             stall,
    input  logic             flush,
    input  logic             EX_MEM_valid,
    input  logic [4:0]       EX_MEM_rd_addr,
    input  logic             EX_MEM_RegWrite,
    input  logic [1:0]       EX_MEM_MemtoReg,
    input  logic [2:0]       EX_MEM_funct3,
    input  logic [XLEN-1:0]  EX_MEM_alu_result,
    input  logic [XLEN-1:0]  EX_MEM_pc_plus4,
    input  logic [XLEN-1:0]  mem_rdata,
    output logic             MEM_WB_valid,
    output logic [4:0]       MEM_WB_rd_addr,
    output logic             MEM_WB_RegWrite,
    output logic [XLEN-1:0]  MEM_WB_wdata,
    output logic [CNT_W-1:0] retired_count
);
    logic [1:0]      off;
    logic [31:0]     word;
    logic [7:0]      byte_sel;
    logic [15:0]     half_sel;
    logic [XLEN-1:0] load_data;
    logic [XLEN-1:0] wb_data;
    logic            capture;

    assign off     = EX_MEM_alu_result[1:0];
    assign word    = mem_rdata[31:0];
    assign capture = !flush && !stall;

    // byte/half extraction from the aligned word, then the write-back select
    always_comb begin
        byte_sel = word[{off, 3'b000} +: 8];
        half_sel = off[1] ? word[31:16] : word[15:0];
        case (EX_MEM_funct3)
            3'b000:  load_data = {{(XLEN-8){byte_sel[7]}}, byte_sel};
            3'b001:  load_data = {{(XLEN-16){half_sel[15]}}, half_sel};
            3'b100:  load_data = {{(XLEN-8){1'b0}}, byte_sel};
            3'b101:  load_data = {{(XLEN-16){1'b0}}, half_sel};
            default: load_data = mem_rdata;
        endcase
        wb_data = EX_MEM_MemtoReg == 2'b00 ? EX_MEM_alu_result :
                  EX_MEM_MemtoReg == 2'b01 ? load_data :
                  EX_MEM_MemtoReg == 2'b10 ? EX_MEM_pc_plus4 : '0;
    end

    // pipeline register: flush inserts a bubble even while stalled
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            MEM_WB_valid    <= 1'b0;
            MEM_WB_rd_addr  <= '0;
            MEM_WB_RegWrite <= 1'b0;
            MEM_WB_wdata    <= '0;
        end else if (flush) begin
            MEM_WB_valid    <= 1'b0;
            MEM_WB_rd_addr  <= '0;
            MEM_WB_RegWrite <= 1'b0;
            MEM_WB_wdata    <= '0;
        end else if (!stall) begin
            MEM_WB_valid    <= EX_MEM_valid;
            MEM_WB_rd_addr  <= EX_MEM_rd_addr;
            MEM_WB_RegWrite <= EX_MEM_valid & EX_MEM_RegWrite;
            MEM_WB_wdata    <= wb_data;
        end
    end

`ifdef RETIRE_CNT_EN
    logic [CNT_W-1:0] cnt;

    // count real instructions entering WB; wraps naturally
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            cnt <= '0;
        else if (capture && EX_MEM_valid)
            cnt <= cnt + CNT_W'(1);
    end

    assign retired_count = cnt;
`else
    assign retired_count = '0;
`endif
endmodule

// File: tb/tb_mem_wb_stage.sv
// tb_mem_wb_stage: randomized and directed checks of mem_wb_stage against a behavioural model
module tb_mem_wb_stage;
`ifdef RETIRE_CNT_EN
    localparam bit CNT_EN = 1'b1;
`else
    localparam bit CNT_EN = 1'b0;
`endif

    logic        clk = 1'b0, rst_n = 1'b0, stall = 1'b0, flush = 1'b0;
    logic        v = 1'b0, rw = 1'b0;
    logic [4:0]  rd = '0;
    logic [1:0]  m2r = '0;
    logic [2:0]  f3 = '0;
    logic [31:0] alu = '0, pc4 = '0, rdata = '0;

    logic        o_valid, o_rw, o_valid4, o_rw4;
    logic [4:0]  o_rd, o_rd4;
    logic [31:0] o_wdata, o_wdata4, o_cnt;
    logic [3:0]  o_cnt4;

    logic        e_valid, e_rw;
    logic [4:0]  e_rd;
    logic [31:0] e_wd, e_cnt, snap;

    int tests = 0, fails = 0;

    mem_wb_stage dut (
        .clk(clk), .rst_n(rst_n), .stall(stall), .flush(flush),
        .EX_MEM_valid(v), .EX_MEM_rd_addr(rd), .EX_MEM_RegWrite(rw),
        .EX_MEM_MemtoReg(m2r), .EX_MEM_funct3(f3), .EX_MEM_alu_result(alu),
        .EX_MEM_pc_plus4(pc4), .mem_rdata(rdata),
        .MEM_WB_valid(o_valid), .MEM_WB_rd_addr(o_rd), .MEM_WB_RegWrite(o_rw),
        .MEM_WB_wdata(o_wdata), .retired_count(o_cnt)
    );

    mem_wb_stage #(.CNT_W(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .stall(stall), .flush(flush),
        .EX_MEM_valid(v), .EX_MEM_rd_addr(rd), .EX_MEM_RegWrite(rw),
        .EX_MEM_MemtoReg(m2r), .EX_MEM_funct3(f3), .EX_MEM_alu_result(alu),
        .EX_MEM_pc_plus4(pc4), .mem_rdata(rdata),
        .MEM_WB_valid(o_valid4), .MEM_WB_rd_addr(o_rd4), .MEM_WB_RegWrite(o_rw4),
        .MEM_WB_wdata(o_wdata4), .retired_count(o_cnt4)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] ref_load(input logic [2:0] f, input logic [31:0] a, input logic [31:0] d);
        int unsigned o  = a % 4;
        int unsigned bv = (d >> (8 * o)) & 32'hFF;
        int unsigned hv = (d >> (16 * (o / 2))) & 32'hFFFF;
        case (f)
            3'd0:    return bv >= 128 ? bv + 32'hFFFFFF00 : bv;
            3'd1:    return hv >= 32768 ? hv + 32'hFFFF0000 : hv;
            3'd4:    return bv;
            3'd5:    return hv;
            default: return d;
        endcase
    endfunction

    function automatic logic [31:0] ref_wb(input logic [1:0] m, input logic [31:0] a, input logic [31:0] p, input logic [31:0] l);
        return m == 2'd0 ? a : m == 2'd1 ? l : m == 2'd2 ? p : 32'd0;
    endfunction

    task automatic model_clear();
        e_valid = 1'b0; e_rw = 1'b0; e_rd = '0; e_wd = '0;
    endtask

    task automatic model_edge();
        if (!rst_n) begin
            model_clear();
            e_cnt = '0;
        end else if (flush) begin
            model_clear();
        end else if (!stall) begin
            e_valid = v;
            e_rw    = v && rw;
            e_rd    = rd;
            e_wd    = ref_wb(m2r, alu, pc4, ref_load(f3, alu, rdata));
            if (v) e_cnt = e_cnt + 1;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".valid"}, {31'd0, o_valid}, {31'd0, e_valid});
        chk({tag, ".regwrite"}, {31'd0, o_rw}, {31'd0, e_rw});
        chk({tag, ".rd"}, {27'd0, o_rd}, {27'd0, e_rd});
        chk({tag, ".wdata"}, o_wdata, e_wd);
        chk({tag, ".count"}, o_cnt, CNT_EN ? e_cnt : 32'd0);
        chk({tag, ".count4"}, {28'd0, o_cnt4}, CNT_EN ? {28'd0, e_cnt[3:0]} : 32'd0);
        chk({tag, ".wdata4"}, o_wdata4, e_wd);
    endtask

    task automatic cyc(input string tag);
        @(posedge clk);
        model_edge();
        #1;
        check_all(tag);
    endtask

    task automatic drive(input logic vv, input logic rww, input logic [4:0] r, input logic [1:0] m,
                         input logic [2:0] f, input logic [31:0] a, input logic [31:0] p, input logic [31:0] d);
        v = vv; rw = rww; rd = r; m2r = m; f3 = f; alu = a; pc4 = p; rdata = d;
    endtask

    initial begin
        model_clear();
        e_cnt = '0;
        drive(1, 1, 5'd9, 2'd0, 3'd0, 32'hDEAD, 32'h44, 32'h1);
        cyc("reset");
        cyc("reset2");
        rst_n = 1'b1;
        drive(1, 1, 5'd5, 2'd0, 3'd2, 32'h1234, 32'h0, 32'h0);
        cyc("alu");
        chk("alu.const", o_wdata, 32'h00001234);
        chk("alu.cnt1", o_cnt, CNT_EN ? 32'd1 : 32'd0);

        drive(1, 1, 5'd3, 2'd1, 3'd0, 32'h100, 32'h0, 32'h80F17F82);
        cyc("lb0");  chk("lb0.const", o_wdata, 32'hFFFFFF82);
        drive(1, 1, 5'd3, 2'd1, 3'd4, 32'h103, 32'h0, 32'h80F17F82);
        cyc("lbu3"); chk("lbu3.const", o_wdata, 32'h00000080);
        drive(1, 1, 5'd3, 2'd1, 3'd1, 32'h102, 32'h0, 32'h80F17F82);
        cyc("lh2");  chk("lh2.const", o_wdata, 32'hFFFF80F1);
        drive(1, 1, 5'd3, 2'd1, 3'd5, 32'h101, 32'h0, 32'h80F17F82);
        cyc("lhu1"); chk("lhu1.const", o_wdata, 32'h00007F82);
        drive(1, 1, 5'd3, 2'd1, 3'd2, 32'h102, 32'h0, 32'h80F17F82);
        cyc("lw2");  chk("lw2.const", o_wdata, 32'h80F17F82);
        drive(1, 1, 5'd3, 2'd1, 3'd7, 32'h101, 32'h0, 32'h80F17F82);
        cyc("ld111"); chk("ld111.const", o_wdata, 32'h80F17F82);

        drive(1, 1, 5'd1, 2'd2, 3'd0, 32'h55, 32'h104, 32'h0);
        cyc("jal");  chk("jal.const", o_wdata, 32'h104);
        drive(1, 1, 5'd1, 2'd3, 3'd0, 32'h55, 32'h104, 32'hFFFF);
        cyc("m2r11"); chk("m2r11.const", o_wdata, 32'h0);

        drive(1, 1, 5'd7, 2'd0, 3'd0, 32'h77, 32'h0, 32'h0);
        cyc("cap7");
        snap = o_cnt;
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            drive(1, 1, 5'(i + 20), 2'(i), 3'd0, 32'(i * 97), 32'h8, 32'hABCD);
            cyc("stall");
        end
        chk("stall.rd7", {27'd0, o_rd}, 32'd7);
        chk("stall.cnt", o_cnt, snap);
        flush = 1'b1;
        cyc("stallflush");
        chk("stallflush.cnt", o_cnt, snap);
        stall = 1'b0;
        cyc("flush");
        flush = 1'b0;

        drive(0, 1, 5'd12, 2'd0, 3'd0, 32'h99, 32'h0, 32'h0);
        cyc("bubble");
        chk("bubble.rw", {31'd0, o_rw}, 32'd0);

        drive(1, 1, 5'd0, 2'd0, 3'd0, 32'h5A5A, 32'h0, 32'h0);
        cyc("x0");
        snap = {28'd0, o_cnt4};
        for (int i = 0; i < 16; i++) begin
            drive(1, 1, 5'(i), 2'd0, 3'd0, 32'(i), 32'h0, 32'h0);
            cyc("wrap");
        end
        chk("wrap.cnt4", {28'd0, o_cnt4}, snap);

        stall = 1'b1;
        @(posedge clk);
        model_edge();
        #2 rst_n = 1'b0;
        #1;
        model_clear();
        e_cnt = '0;
        check_all("async_rst");
        @(negedge clk);
        rst_n = 1'b1;
        stall = 1'b0;

        for (int i = 0; i < 400; i++) begin
            stall = ($urandom % 4) == 0;
            flush = ($urandom % 8) == 0;
            drive(1'($urandom), 1'($urandom), 5'($urandom), 2'($urandom), 3'($urandom),
                  $urandom, $urandom, $urandom);
            cyc("rand");
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
